// File: rtl/mipspkg.sv
// Shared types for the MIPS-lite hazard/stall controller: register width,
// controller states and the per-stage scoreboard entry.
package mipspkg;

    localparam int REG_WIDTH          = 5;
    localparam int PIPE_DEPTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [REG_WIDTH-1:0] dest;
        logic                 halt;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when an in-flight entry will write a register the decode instruction reads.
    function automatic logic entry_hits(
        input sb_entry_t            e,
        input logic [REG_WIDTH-1:0] src_a,
        input logic [REG_WIDTH-1:0] src_b,
        input logic                 uses_b
    );
        return e.valid && e.wr && (e.dest != '0) &&
               ((e.dest == src_a) || (uses_b && (e.dest == src_b)));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations (stage 1 = EX, stage
// PIPE_DEPTH = WB) with RAW comparators against the decode sources.
module hazard_scoreboard
    import mipspkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_load,
    input  sb_entry_t            i_entry,
    input  logic                 i_valid,
    input  logic [REG_WIDTH-1:0] i_src_a,
    input  logic [REG_WIDTH-1:0] i_src_b,
    input  logic                 i_uses_b,
    output logic                 o_raw_hit,
    output logic                 o_halt_at_wb,
    output logic                 o_pipe_empty
);

    sb_entry_t r_stage [1:PIPE_DEPTH];
    logic      w_hit;
    logic      w_any_valid;

    // NOTE: the stage array is a handful of flops, not a RAM, so it is reset
    // like any other state; a reset mid-stall must not leave stale hazards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 1; s <= PIPE_DEPTH; s++) begin
                r_stage[s] <= SB_BUBBLE;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage see its
            // predecessor's old value, which is what makes this a shift.
            r_stage[1] <= i_load ? i_entry : SB_BUBBLE;
            for (int s = 2; s <= PIPE_DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    // The WB stage is compared too: the register file cannot write then read in one cycle.
    always_comb begin
        // NOTE: defaults first so no path through the loop can infer a latch.
        w_hit       = 1'b0;
        w_any_valid = 1'b0;
        for (int s = 1; s <= PIPE_DEPTH; s++) begin
            w_hit       = w_hit | entry_hits(r_stage[s], i_src_a, i_src_b, i_uses_b);
            w_any_valid = w_any_valid | r_stage[s].valid;
        end
    end

    assign o_raw_hit    = i_valid & w_hit;
    assign o_halt_at_wb = r_stage[PIPE_DEPTH].valid & r_stage[PIPE_DEPTH].halt;
    assign o_pipe_empty = ~w_any_valid;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage stall/issue sequencer with HALT drain for the non-forwarding
// 5-stage pipeline. Optional stall statistics under STALL_STATS_EN.
module hazard_stall_controller
    import mipspkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
`ifdef STALL_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_WIDTH-1:0] id_src_a,
    input  logic [REG_WIDTH-1:0] id_src_b,
    input  logic                 id_uses_b,
    input  logic [REG_WIDTH-1:0] id_dest,
    input  logic                 id_writes_reg,
    input  logic                 id_is_halt,
    output logic                 stall,
    output logic                 id_issue,
    output logic                 pipe_empty,
    output logic                 halt_detected
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     raw_events
`endif
);

    hz_state_e r_state;
    hz_state_e w_state_nxt;
    sb_entry_t w_entry;
    logic      w_raw_hit;
    logic      w_halt_at_wb;
    logic      w_sb_empty;
    logic      w_stall;
    logic      w_issue;
    logic      w_halt_det;

    // HALT enters the pipe as a non-writing, halt-tagged entry.
    assign w_entry = '{valid: 1'b1,
                       wr:    id_writes_reg & ~id_is_halt,
                       dest:  id_dest,
                       halt:  id_is_halt};

    hazard_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .i_load       (id_issue),
        .i_entry      (w_entry),
        .i_valid      (id_valid),
        .i_src_a      (id_src_a),
        .i_src_b      (id_src_b),
        .i_uses_b     (id_uses_b),
        .o_raw_hit    (w_raw_hit),
        .o_halt_at_wb (w_halt_at_wb),
        .o_pipe_empty (w_sb_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_issue     = 1'b0;
        w_halt_det  = 1'b0;
        unique case (r_state)
            RUN: begin
                w_stall = w_raw_hit;
                w_issue = id_valid & ~w_raw_hit;
                if (w_issue && id_is_halt) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                // WriteBack sees halt_detected in the same cycle HALT reaches it.
                if (w_halt_at_wb) begin
                    w_halt_det  = 1'b1;
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                w_stall    = 1'b1;
                w_halt_det = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    assign stall         = w_stall & ~reset;
    assign id_issue      = w_issue & ~reset;
    assign halt_detected = w_halt_det & ~reset;
    assign pipe_empty    = w_sb_empty | reset;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_raw_events;
    logic             r_raw_prev;
    logic             w_raw_stall;

    assign w_raw_stall = (r_state == RUN) & w_raw_hit & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_raw_events   <= '0;
            r_raw_prev     <= 1'b0;
        end else begin
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_raw_stall && !r_raw_prev && (r_raw_events != '1)) begin
                r_raw_events <= r_raw_events + CNT_W'(1);
            end
            r_raw_prev <= w_raw_stall;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign raw_events   = r_raw_events;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios then
// random traffic, checked against a register-busy-window reference model.
module tb_hazard_stall_controller;
    import mipspkg::*;

    localparam int DEPTH = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_src_a = '0;
    logic [4:0] id_src_b = '0;
    logic       id_uses_b = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_writes_reg = 1'b0;
    logic       id_is_halt = 1'b0;
    logic       stall;
    logic       id_issue;
    logic       pipe_empty;
    logic       halt_detected;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] raw_events;
`endif

    hazard_stall_controller dut (
        .clock         (clock),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_src_a      (id_src_a),
        .id_src_b      (id_src_b),
        .id_uses_b     (id_uses_b),
        .id_dest       (id_dest),
        .id_writes_reg (id_writes_reg),
        .id_is_halt    (id_is_halt),
        .stall         (stall),
        .id_issue      (id_issue),
        .pipe_empty    (pipe_empty),
        .halt_detected (halt_detected)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .raw_events    (raw_events)
`endif
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: a register written by an instruction issued in cycle c is unreadable
    // through cycle c+DEPTH; the pipe is empty once DEPTH cycles pass after the last issue.
    int cyc = 0;
    int busy [32];
    int last_issue;
    int halt_cyc;
    int m_stalls;
    int m_raws;
    bit m_raw_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy[i] = -100;
        last_issue = -100;
        halt_cyc   = -1;
        m_stalls   = 0;
        m_raws     = 0;
        m_raw_prev = 1'b0;
    endtask

    task automatic step(input string tag, input bit rst, input bit v, input int a, input int b,
                        input bit ub, input int d, input bit wr, input bit h);
        bit raw, e_stall, e_issue, e_empty, e_halt;
        reset         = rst;
        id_valid      = v;
        id_src_a      = 5'(a);
        id_src_b      = 5'(b);
        id_uses_b     = ub;
        id_dest       = 5'(d);
        id_writes_reg = wr;
        id_is_halt    = h;
        @(negedge clock);
        raw = 1'b0;
        if (rst) begin
            e_stall = 1'b0; e_issue = 1'b0; e_empty = 1'b1; e_halt = 1'b0;
        end else if (halt_cyc >= 0) begin
            e_stall = 1'b1;
            e_issue = 1'b0;
            e_halt  = (cyc >= halt_cyc + DEPTH);
            e_empty = (cyc > last_issue + DEPTH);
        end else begin
            raw = v && ((a != 0 && cyc <= busy[a]) || (ub && b != 0 && cyc <= busy[b]));
            e_stall = raw;
            e_issue = v && !raw;
            e_halt  = 1'b0;
            e_empty = (cyc > last_issue + DEPTH);
        end
        check({tag, "/stall"}, 32'(stall), 32'(e_stall));
        check({tag, "/id_issue"}, 32'(id_issue), 32'(e_issue));
        check({tag, "/pipe_empty"}, 32'(pipe_empty), 32'(e_empty));
        check({tag, "/halt_detected"}, 32'(halt_detected), 32'(e_halt));
`ifdef STALL_STATS_EN
        check({tag, "/stall_cycles"}, stall_cycles, 32'(m_stalls));
        check({tag, "/raw_events"}, raw_events, 32'(m_raws));
`endif
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            if (e_stall) m_stalls++;
            if (raw && !m_raw_prev) m_raws++;
            m_raw_prev = raw;
            if (e_issue) begin
                last_issue = cyc;
                if (h) halt_cyc = cyc;
                else if (wr && d != 0) busy[d] = cyc + DEPTH;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset held two cycles with a valid decode instruction present
        step("reset", 1, 1, 3, 4, 1, 5, 1, 0);
        step("reset", 1, 1, 3, 4, 1, 5, 1, 0);

        // ADD r3 then dependent SUB: three stall cycles, issue on the fourth
        step("raw_add", 0, 1, 1, 2, 1, 3, 1, 0);
        repeat (4) step("raw_sub", 0, 1, 3, 0, 0, 4, 1, 0);
`ifdef STALL_STATS_EN
        check("stats_stall_after_raw", stall_cycles, 32'd3);
        check("stats_raw_after_raw", raw_events, 32'd1);
`endif

        // r0 writer/reader and a non-writing store never stall
        step("r0_wr", 0, 1, 1, 1, 0, 0, 1, 0);
        step("r0_rd", 0, 1, 0, 0, 1, 0, 0, 0);
        step("sw", 0, 1, 8, 6, 1, 6, 0, 0);
        step("sw_rd", 0, 1, 6, 0, 0, 0, 0, 0);

        // rt comparison only when id_uses_b is set
        step("wr5", 0, 1, 0, 0, 0, 5, 1, 0);
        step("b_masked", 0, 1, 0, 5, 0, 0, 0, 0);
        step("wr5", 0, 1, 0, 0, 0, 5, 1, 0);
        repeat (4) step("b_used", 0, 1, 0, 5, 1, 0, 0, 0);

        // ADD r1 then HALT: drain, halt_detected three cycles after HALT issues, held
        step("h_add", 0, 1, 0, 0, 0, 1, 1, 0);
        step("h_halt", 0, 1, 0, 0, 0, 0, 0, 1);
        repeat (7) step("h_drain", 0, 1, 1, 2, 1, 9, 1, 0);

        // Reset in the middle of a drain returns to RUN with an empty pipe
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        step("m_add", 0, 1, 0, 0, 0, 2, 1, 0);
        step("m_halt", 0, 1, 0, 0, 0, 0, 0, 1);
        step("m_drain", 0, 1, 0, 0, 0, 0, 0, 0);
        step("m_reset", 1, 1, 2, 2, 1, 2, 1, 0);
        step("m_after", 0, 1, 2, 2, 1, 3, 1, 0);

        // Random traffic over a small register set so hazards are frequent
        for (int bt = 0; bt < 3; bt++) begin
            step("rnd_reset", 1, 0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 150; k++) begin
                step("rnd", 0,
                     ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 1),
                     int'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 59) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
